// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one single-port unified instruction/data memory between the fetch
// stage and the load/store stage. At most one access is issued per cycle.
// Data accesses normally win; a saturating wait counter guarantees fetch is
// served after MAX_WAIT consecutive denied cycles. Read data is steered back
// to whichever requester issued the read one cycle earlier.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   if_req/if_addr      fetch read request and PC
//   if_grant            fetch access issued this cycle
//   if_rvalid/if_rdata  instruction return (rdata is 0 when not valid)
//   stall_fetch         fetch requested but lost arbitration this cycle
//   d_req/d_we/d_addr/d_wdata  load/store request
//   d_grant             data access issued this cycle
//   d_rvalid/d_rdata    load return (rdata is 0 when not valid)
//   mem_en/mem_we/mem_addr/mem_wdata  memory command (all 0 when idle)
//   mem_rdata           memory read data, one cycle after a read command
//
// MAX_WAIT must lie in 1..15 so it fits the 4-bit wait counter.

module mem_port_arbiter #(
  parameter int ADDRESS_BITS = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_WAIT     = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  // fetch port
  input  logic                    if_req,
  input  logic [ADDRESS_BITS-1:0] if_addr,
  output logic                    if_grant,
  output logic                    if_rvalid,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  output logic                    stall_fetch,
  // load/store port
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDRESS_BITS-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  output logic                    d_grant,
  output logic                    d_rvalid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  // memory port
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDRESS_BITS-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  // Owner of the read issued in the previous cycle.
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

  localparam logic [3:0] MAX_WAIT_CNT = 4'(MAX_WAIT);

  logic [3:0] wait_cnt_reg;
  logic [3:0] wait_cnt_next;
  logic [1:0] rd_owner_reg;
  logic [1:0] rd_owner_next;
  logic       fetch_wins;

  // ---------------------------------------------------------------------
  // Grant decision: fetch wins when uncontested or when it has waited
  // MAX_WAIT cycles; data takes the port otherwise. Giving d_grant only
  // when fetch is not granted makes the grants mutually exclusive.
  // ---------------------------------------------------------------------
  always_comb begin
    fetch_wins = ~d_req | (wait_cnt_reg == MAX_WAIT_CNT);
  end

  assign if_grant    = if_req & fetch_wins;
  assign d_grant     = d_req & ~if_grant;
  assign stall_fetch = if_req & ~if_grant;

  // ---------------------------------------------------------------------
  // Memory command mux; everything is driven to 0 when idle so the
  // memory bus is quiet between accesses.
  // ---------------------------------------------------------------------
  always_comb begin
    mem_en    = if_grant | d_grant;
    mem_we    = d_grant & d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (if_grant) begin
      mem_addr = if_addr;
    end else if (d_grant) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic.
  // The wait counter only tracks an uninterrupted run of denied fetch
  // cycles, so a grant or a dropped request restarts it.
  // ---------------------------------------------------------------------
  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (if_grant || !if_req) begin
      wait_cnt_next = 4'd0;
    end else if (wait_cnt_reg < MAX_WAIT_CNT) begin
      wait_cnt_next = wait_cnt_reg + 4'd1;
    end
  end

  // Stores never produce a return, so only reads record an owner.
  always_comb begin
    rd_owner_next = OWN_NONE;
    if (if_grant) begin
      rd_owner_next = OWN_IF;
    end else if (d_grant && !d_we) begin
      rd_owner_next = OWN_D;
    end
  end

  // Asynchronous reset drops any read in flight: the owner is cleared
  // immediately, so no rvalid appears after reset releases.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt_reg <= 4'd0;
      rd_owner_reg <= OWN_NONE;
    end else begin
      wait_cnt_reg <= wait_cnt_next;
      rd_owner_reg <= rd_owner_next;
    end
  end

  // ---------------------------------------------------------------------
  // Read return steering. The inactive port sees zeros rather than the
  // shared memory bus, so no instruction leaks into load data or back.
  // ---------------------------------------------------------------------
  assign if_rvalid = (rd_owner_reg == OWN_IF);
  assign d_rvalid  = (rd_owner_reg == OWN_D);

  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH; gi = gi + 1) begin : g_rdata_gate
      assign if_rdata[gi] = mem_rdata[gi] & if_rvalid;
      assign d_rdata[gi]  = mem_rdata[gi] & d_rvalid;
    end
  endgenerate

endmodule
